// File: rtl/zaxmem_pkg.sv
// Shared definitions for the zaxmem AXI4 memory responder: burst and
// response encodings, FSM state type, and the burst-legality check.
package zaxmem_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_WRESP, ST_READ} state_t;

    typedef struct packed {
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
    } burst_t;

    // Reserved burst type, beats wider than the bus, or an illegal wrap length.
    function automatic logic burst_err(input burst_t b, input int lg_bytes);
        logic bad;
        bad = (b.burst == 2'b11) || (int'(b.size) > lg_bytes);
        if (b.burst == BURST_WRAP && !(b.len inside {8'd1, 8'd3, 8'd7, 8'd15}))
            bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/zaxmem_nextaddr.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts,
// shared by the read and write paths of zaxmem.
module zaxmem_nextaddr
    import zaxmem_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic [AW-1:0] addr,
    input  burst_t        bt,
    output logic [AW-1:0] next_addr
);

    logic [AW-1:0] sz, aligned, incr, wlen, wmask;
    logic          unused_len;

    // Legal wrap lengths never exceed 16 beats, so only len[3:0] matters.
    assign unused_len = &{1'b0, bt.len[7:4]};

    always_comb begin
        sz      = AW'(1) << bt.size;
        aligned = addr & ~(sz - AW'(1));
        incr    = aligned + sz;
        wlen    = (AW'(bt.len[3:0]) + AW'(1)) << bt.size;
        wmask   = wlen - AW'(1);
        case (bt.burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~wmask) | (incr & wmask);
            default:     next_addr = incr;
        endcase
    end

endmodule

// File: rtl/zaxmem.sv
// AXI4 slave memory: one read or write burst at a time against a
// byte-strobed on-chip RAM of 2^LGMEMSZ bytes.
module zaxmem
    import zaxmem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 30,
    parameter int LGMEMSZ       = 12,
    parameter int BUS_WIDTH     = 32,
    parameter int IW            = 2,
    parameter bit OPT_LOWPOWER  = 1'b0
) (
    input  logic                     i_clk,
    input  logic                     i_reset,

    input  logic                     S_AXI_AWVALID,
    output logic                     S_AXI_AWREADY,
    input  logic [IW-1:0]            S_AXI_AWID,
    input  logic [ADDRESS_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [7:0]               S_AXI_AWLEN,
    input  logic [2:0]               S_AXI_AWSIZE,
    input  logic [1:0]               S_AXI_AWBURST,
    input  logic                     S_AXI_AWLOCK,
    input  logic [3:0]               S_AXI_AWCACHE,
    input  logic [2:0]               S_AXI_AWPROT,
    input  logic [3:0]               S_AXI_AWQOS,

    input  logic                     S_AXI_WVALID,
    output logic                     S_AXI_WREADY,
    input  logic [BUS_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [BUS_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                     S_AXI_WLAST,

    output logic                     S_AXI_BVALID,
    input  logic                     S_AXI_BREADY,
    output logic [IW-1:0]            S_AXI_BID,
    output logic [1:0]               S_AXI_BRESP,

    input  logic                     S_AXI_ARVALID,
    output logic                     S_AXI_ARREADY,
    input  logic [IW-1:0]            S_AXI_ARID,
    input  logic [ADDRESS_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [7:0]               S_AXI_ARLEN,
    input  logic [2:0]               S_AXI_ARSIZE,
    input  logic [1:0]               S_AXI_ARBURST,
    input  logic                     S_AXI_ARLOCK,
    input  logic [3:0]               S_AXI_ARCACHE,
    input  logic [2:0]               S_AXI_ARPROT,
    input  logic [3:0]               S_AXI_ARQOS,

    output logic                     S_AXI_RVALID,
    input  logic                     S_AXI_RREADY,
    output logic [IW-1:0]            S_AXI_RID,
    output logic [BUS_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]               S_AXI_RRESP,
    output logic                     S_AXI_RLAST
);

    localparam int DW     = BUS_WIDTH;
    localparam int LGB    = $clog2(DW/8);
    localparam int NWORDS = 1 << (LGMEMSZ - LGB);

    state_t               state;
    logic                 prio_rd;
    burst_t               bt, grant_bt;
    logic [IW-1:0]        id_q;
    logic [LGMEMSZ-1:0]   addr_q, next_addr;
    logic [7:0]           cnt;
    logic                 err, rd_done;
    logic                 wready_q, bvalid_q, rvalid_q, rlast_q;
    logic [1:0]           bresp_q, rresp_q;
    logic [DW-1:0]        rdata_q;
    logic [DW-1:0]        mem [0:NWORDS-1];

    logic                 aw_hs, ar_hs, w_hs, w_final, w_bad, r_issue;
    logic [LGMEMSZ-LGB-1:0] widx;
    logic                 unused_ok;

    assign unused_ok = &{1'b0, S_AXI_AWADDR[ADDRESS_WIDTH-1:LGMEMSZ],
                         S_AXI_ARADDR[ADDRESS_WIDTH-1:LGMEMSZ],
                         S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS,
                         S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS};

    // At most one of the two READYs can be high while the other VALID is up.
    always_comb begin
        S_AXI_AWREADY = !i_reset && (state == ST_IDLE) && (!S_AXI_ARVALID || !prio_rd);
        S_AXI_ARREADY = !i_reset && (state == ST_IDLE) && (!S_AXI_AWVALID || prio_rd);
        aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
        ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
        grant_bt.len   = aw_hs ? S_AXI_AWLEN   : S_AXI_ARLEN;
        grant_bt.size  = aw_hs ? S_AXI_AWSIZE  : S_AXI_ARSIZE;
        grant_bt.burst = aw_hs ? S_AXI_AWBURST : S_AXI_ARBURST;
        w_hs    = S_AXI_WVALID && wready_q;
        w_final = (cnt == bt.len);
        w_bad   = (S_AXI_WLAST != w_final);
        r_issue = (state == ST_READ) && !rd_done && (!rvalid_q || S_AXI_RREADY);
        widx    = addr_q[LGMEMSZ-1:LGB];
    end

    zaxmem_nextaddr #(.AW(LGMEMSZ)) u_nextaddr (
        .addr      (addr_q),
        .bt        (bt),
        .next_addr (next_addr)
    );

    // A beat whose WLAST disagrees with the count is dropped along with the rest.
    always_ff @(posedge i_clk) begin
        if (w_hs && !err && !w_bad)
            for (int b = 0; b < DW/8; b++)
                if (S_AXI_WSTRB[b])
                    mem[widx][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= ST_IDLE;
            prio_rd  <= 1'b0;
            bt       <= '0;
            id_q     <= '0;
            addr_q   <= '0;
            cnt      <= '0;
            err      <= 1'b0;
            rd_done  <= 1'b0;
            wready_q <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: if (aw_hs || ar_hs) begin
                    bt      <= grant_bt;
                    id_q    <= aw_hs ? S_AXI_AWID : S_AXI_ARID;
                    addr_q  <= aw_hs ? S_AXI_AWADDR[LGMEMSZ-1:0] : S_AXI_ARADDR[LGMEMSZ-1:0];
                    cnt     <= '0;
                    err     <= burst_err(grant_bt, LGB);
                    rd_done <= 1'b0;
                    if (S_AXI_AWVALID && S_AXI_ARVALID)
                        prio_rd <= !prio_rd;
                    if (aw_hs) begin
                        state    <= ST_WRITE;
                        wready_q <= 1'b1;
                    end else begin
                        state    <= ST_READ;
                    end
                end
                ST_WRITE: if (w_hs) begin
                    if (w_final) begin
                        wready_q <= 1'b0;
                        bvalid_q <= 1'b1;
                        bresp_q  <= (err || w_bad) ? RESP_SLVERR : RESP_OKAY;
                        state    <= ST_WRESP;
                    end else begin
                        cnt    <= cnt + 8'd1;
                        addr_q <= next_addr;
                        err    <= err || w_bad;
                    end
                end
                ST_WRESP: if (S_AXI_BREADY) begin
                    bvalid_q <= 1'b0;
                    state    <= ST_IDLE;
                end
                ST_READ: begin
                    // The output register doubles as the RAM read stage.
                    if (r_issue) begin
                        rvalid_q <= 1'b1;
                        rlast_q  <= (cnt == bt.len);
                        rresp_q  <= err ? RESP_SLVERR : RESP_OKAY;
                        rdata_q  <= err ? '0 : mem[widx];
                        addr_q   <= next_addr;
                        cnt      <= cnt + 8'd1;
                        rd_done  <= (cnt == bt.len);
                    end else if (rvalid_q && S_AXI_RREADY) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign S_AXI_WREADY = wready_q;
    assign S_AXI_BVALID = bvalid_q;
    assign S_AXI_BID    = id_q;
    assign S_AXI_BRESP  = bresp_q;
    assign S_AXI_RVALID = rvalid_q;
    assign S_AXI_RID    = id_q;
    assign S_AXI_RRESP  = rresp_q;
    assign S_AXI_RLAST  = rlast_q;
    assign S_AXI_RDATA  = (OPT_LOWPOWER && !rvalid_q) ? '0 : rdata_q;

endmodule

// File: doc/zaxmem.md
# zaxmem

AXI4 full-protocol memory responder: the slave end of the bus the ZipCPU DMA master drives. Serves one read or write burst at a time from an on-chip byte-strobed RAM of 2^LGMEMSZ bytes, supporting FIXED, INCR and WRAP bursts and narrow transfers. Used as the DMA's on-chip scratchpad and as the bench target for `zaxdma`.

## Interface
- ADDRESS_WIDTH, 30: width of AWADDR/ARADDR.
- LGMEMSZ, 12: log2 of memory size in bytes; only address bits [LGMEMSZ-1:0] are decoded.
- BUS_WIDTH, 32: data width DW; power of two, 32 to 512.
- IW, 2: AXI ID width.
- OPT_LOWPOWER, 0: when 1, RDATA is zeroed whenever RVALID is low.
- i_clk  in  1  clock; one clock domain.
- i_reset  in  1  asynchronous, active-high reset.
- S_AXI_AW{VALID,READY,ID,ADDR,LEN,SIZE,BURST,LOCK,CACHE,PROT,QOS}  in/out  standard AXI4 write-address channel (READY is output).
- S_AXI_W{VALID,READY,DATA,STRB,LAST}  in/out  1,1,DW,DW/8,1  write data.
- S_AXI_B{VALID,READY,ID,RESP}  out/in  1,1,IW,2  write response.
- S_AXI_AR{...}  in/out  read address, same fields as AW.
- S_AXI_R{VALID,READY,ID,DATA,RESP,LAST}  out/in  1,1,IW,DW,2,1  read data.

## Operation
- FSM states: IDLE, WRITE, WRESP, READ. Reset: IDLE, every VALID/READY output 0, RDATA/BID/RID 0, priority = write.
- IDLE arbitration: AWREADY = IDLE && (!ARVALID || prio==write); ARREADY = IDLE && (!AWVALID || prio==read). Only one handshake per cycle. After each granted burst, prio flips to the other direction if both were requesting; otherwise unchanged.
- On grant: latch ID, addr, LEN, SIZE, BURST; beat counter = 0. Error flag set if BURST==2'b11, 2^SIZE > DW/8, or WRAP with LEN not in {1,3,7,15}.
- WRITE: WREADY=1; each accepted beat writes bytes enabled by WSTRB at word addr[LGMEMSZ-1:log2(DW/8)], unless error flag set (then no write). Final beat is counter==LEN; WLAST disagreeing with counter at any beat sets error flag. After final beat → WRESP.
- WRESP: BVALID=1, BID=latched ID, BRESP = error ? SLVERR(2'b10) : OKAY. Held until BREADY → IDLE.
- READ: returns LEN+1 beats; RID latched, RLAST on beat LEN, RRESP per error flag; RDATA = full bus word containing the beat address, or 0 on error. After RLAST handshake → IDLE.
- Address sequencing per beat: FIXED constant; INCR = (addr aligned to 2^SIZE) + 2^SIZE; WRAP wraps within boundary (LEN+1)·2^SIZE. Addresses above memory alias modulo 2^LGMEMSZ; no DECERR.
- Address ignores AxLOCK/CACHE/PROT/QOS.

## Timing
- AR handshake at cycle N → first RVALID at N+2 (address register, then registered RAM read). With RREADY held high, one beat per cycle, no bubbles.
- RREADY low: RVALID/RDATA/RLAST stable; RAM read and address advance stall; no beat lost or duplicated.
- Write: one beat per cycle while WVALID; BVALID the cycle after the final W handshake.
- Back-to-back: next AW/AR accepted the cycle after B or final R handshake completes (IDLE for ≥1 cycle).
- W beats arriving before AW are not accepted (WREADY=0 outside WRITE).
- Async reset mid-burst: all outputs drop to reset values immediately; RAM contents undefined-but-unchanged by reset; partial write beats already committed remain.

## Structure
- Shared package/header (zaxdma common): burst encodings FIXED/INCR/WRAP, response codes OKAY/SLVERR.
- Sub-module `zaxmem_nextaddr`: combinational next-beat address from addr, SIZE, LEN, BURST; shared by read and write paths.
- RAM as inferred byte-enabled single-port array in the top.

## Test plan
- INCR write AWADDR=0x100, LEN=3, SIZE=2, data 1,2,3,4, WSTRB=0xF → BRESP=OKAY; INCR read same → RDATA 1,2,3,4, RLAST on 4th, first RVALID 2 cycles after AR handshake.
- WRAP read ARADDR=0x108, LEN=3, SIZE=2 → beat addresses 0x108,0x10C,0x100,0x104.
- Simultaneous AWVALID and ARVALID after reset → write granted first, then read; repeated → alternates.
- Write LEN=1 with WLAST on first beat → BRESP=SLVERR, memory unchanged; BURST=2'b11 read → RRESP=SLVERR, RDATA=0 for all LEN+1 beats.
- Random RREADY backpressure on LEN=15 read → 16 beats in order, none dropped or duplicated; narrow SIZE=0 writes at 0x200..0x203 with single strobes → read word 0x200 returns assembled bytes.
- Assert i_reset during beat 2 of a LEN=7 read → RVALID=0 same cycle; after release, new read returns correct data.
